// File: rtl/cu_pkg.sv
// Shared types, opcode/func encodings and the decode table for the multicycle control unit.
// CU_LONGOP_EN adds the LONG state and the multiply-class function decode.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
`ifdef CU_LONGOP_EN
        ST_LONG   = 3'd3,
`endif
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_LONG, CLS_HALT, CLS_NONE
    } cls_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100010;
    localparam logic [5:0] OP_BLT  = 6'b100101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b111110;

    localparam logic [5:0] FN_HALT = 6'b000000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MUL  = 6'b011000;

    // Control word layout, LSB first: b_src[1:0], op_sel, ext_sel, reg_dst[1:0],
    // wb_src[1:0], mem_write, reg_write, pc_src[1:0].
    localparam int CW_W         = 12;
    localparam int CW_B_SRC     = 0;
    localparam int CW_OP_SEL    = 2;
    localparam int CW_EXT_SEL   = 3;
    localparam int CW_REG_DST   = 4;
    localparam int CW_WB_SRC    = 6;
    localparam int CW_MEM_WRITE = 8;
    localparam int CW_REG_WRITE = 9;
    localparam int CW_PC_SRC    = 10;

    //                                     pc_src reg_w mem_w wb_src reg_dst ext  op   b_src
    localparam logic [CW_W-1:0] CW_RTYPE  = {2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00};
    localparam logic [CW_W-1:0] CW_LOAD   = {2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01};
    localparam logic [CW_W-1:0] CW_STORE  = {2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
    localparam logic [CW_W-1:0] CW_BRANCH = {2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00};
    localparam logic [CW_W-1:0] CW_JUMP   = {2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [CW_W-1:0] CW_MUL    = {2'b00, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 2'b00};

    typedef struct packed {
        logic [CW_W-1:0] word;
        cls_e            cls;
        logic            legal;
    } dec_t;

    function automatic dec_t cu_decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d.word  = '0;
        d.cls   = CLS_NONE;
        d.legal = 1'b0;
        case (op)
            OP_R: begin
                if (fn == FN_HALT) begin
                    d.cls   = CLS_HALT;
                    d.legal = 1'b1;
                end else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                    d.word  = CW_RTYPE;
                    d.cls   = CLS_R;
                    d.legal = 1'b1;
                end
`ifdef CU_LONGOP_EN
                else if (fn == FN_MUL) begin
                    d.word  = CW_MUL;
                    d.cls   = CLS_LONG;
                    d.legal = 1'b1;
                end
`endif
            end
            OP_LW: begin
                d.word  = CW_LOAD;
                d.cls   = CLS_LOAD;
                d.legal = 1'b1;
            end
            OP_SW: begin
                d.word  = CW_STORE;
                d.cls   = CLS_STORE;
                d.legal = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGTZ, OP_BLEZ: begin
                d.word  = CW_BRANCH;
                d.cls   = CLS_BRANCH;
                d.legal = 1'b1;
            end
            OP_J: begin
                d.word  = CW_JUMP;
                d.cls   = CLS_JUMP;
                d.legal = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cu_watchdog.sv
// Wait-cycle counter for the control unit; o_expire flags the last permitted wait cycle
// so the FSM can still let a same-cycle completion win over the fault.
module cu_watchdog #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [TMO_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TMO_W'(1);
        end
    end

    assign o_expire = (r_count == TMO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshake and watchdog.
// Define CU_LONGOP_EN to enable the LONG state and the alu_start/alu_done handshake.
module multicycle_control_fsm
    import cu_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int FUNC_W      = 6,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic              zero,
    input  logic              mem_ready,
    input  logic              alu_done,
    output logic              ir_load,
    output logic              pc_load,
    output logic              mem_req,
    output logic              cu_mem_write,
    output logic              cu_reg_write,
    output logic              cu_op_sel,
    output logic              cu_ext_sel,
    output logic [1:0]        cu_pc_src,
    output logic [1:0]        cu_reg_dst,
    output logic [1:0]        cu_b_src,
    output logic [1:0]        cu_wb_src,
    output logic              alu_start,
    output logic              halted,
    output logic              fault
);

    state_e          r_state;
    state_e          w_next_state;
    logic [CW_W-1:0] r_word;
    cls_e            r_class;
    logic            r_active;
    dec_t            w_dec;
    logic            w_waiting;
    logic            w_wd_clear;
    logic            w_wd_expire;

    assign w_dec = cu_decode(opcode, func);

    // r_active is low for the cycle following a reset edge, holding every control at 0 then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_word   <= '0;
            r_class  <= CLS_NONE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_active <= 1'b1;
            if (r_state == ST_DECODE) begin
                r_word  <= w_dec.word;
                r_class <= w_dec.cls;
            end
        end
    end

`ifdef CU_LONGOP_EN
    logic r_long_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_long_entry <= 1'b0;
        end else begin
            r_long_entry <= (r_state == ST_EXEC) && (w_next_state == ST_LONG);
        end
    end
`else
    logic w_unused_alu_done;
    assign w_unused_alu_done = alu_done;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_waiting    = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        mem_req      = 1'b0;
        cu_mem_write = 1'b0;
        cu_reg_write = 1'b0;
        cu_op_sel    = 1'b0;
        cu_ext_sel   = 1'b0;
        cu_pc_src    = 2'b00;
        cu_reg_dst   = 2'b00;
        cu_b_src     = 2'b00;
        cu_wb_src    = 2'b00;
        alu_start    = 1'b0;
        if (r_active) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    w_waiting = !mem_ready;
                    if (mem_ready) begin
                        ir_load      = 1'b1;
                        pc_load      = 1'b1;
                        w_next_state = ST_DECODE;
                    end else if (w_wd_expire) begin
                        w_next_state = ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    if (!w_dec.legal)              w_next_state = ST_FAULT;
                    else if (w_dec.cls == CLS_HALT) w_next_state = ST_HALT;
                    else                           w_next_state = ST_EXEC;
                end
                ST_EXEC: begin
                    cu_b_src   = r_word[CW_B_SRC +: 2];
                    cu_op_sel  = r_word[CW_OP_SEL];
                    cu_ext_sel = r_word[CW_EXT_SEL];
                    case (r_class)
                        CLS_R:               w_next_state = ST_WB;
                        CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
                        CLS_BRANCH: begin
                            pc_load      = 1'b1;
                            cu_pc_src    = zero ? 2'b00 : r_word[CW_PC_SRC +: 2];
                            w_next_state = ST_FETCH;
                        end
                        CLS_JUMP: begin
                            pc_load      = 1'b1;
                            cu_pc_src    = r_word[CW_PC_SRC +: 2];
                            w_next_state = ST_FETCH;
                        end
`ifdef CU_LONGOP_EN
                        CLS_LONG:            w_next_state = ST_LONG;
`endif
                        default:             w_next_state = ST_FAULT;
                    endcase
                end
`ifdef CU_LONGOP_EN
                ST_LONG: begin
                    alu_start = r_long_entry;
                    w_waiting = !alu_done;
                    if (alu_done)         w_next_state = ST_WB;
                    else if (w_wd_expire) w_next_state = ST_FAULT;
                end
`endif
                ST_MEM: begin
                    mem_req      = 1'b1;
                    cu_mem_write = r_word[CW_MEM_WRITE];
                    w_waiting    = !mem_ready;
                    if (mem_ready) begin
                        w_next_state = (r_class == CLS_STORE) ? ST_FETCH : ST_WB;
                    end else if (w_wd_expire) begin
                        w_next_state = ST_FAULT;
                    end
                end
                ST_WB: begin
                    cu_reg_write = r_word[CW_REG_WRITE];
                    cu_reg_dst   = r_word[CW_REG_DST +: 2];
                    cu_wb_src    = r_word[CW_WB_SRC +: 2];
                    w_next_state = ST_FETCH;
                end
                ST_HALT, ST_FAULT: ;
                default: w_next_state = ST_FAULT;
            endcase
        end
    end

    // Any state change restarts the wait count, so each FETCH/MEM/LONG visit starts at zero.
    assign w_wd_clear = (w_next_state != r_state);

    cu_watchdog #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_wd_clear),
        .i_enable (w_waiting),
        .o_expire (w_wd_expire)
    );

    assign halted = (r_state == ST_HALT);
    assign fault  = (r_state == ST_FAULT);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; the long-op step follows CU_LONGOP_EN.
module tb_multicycle_control_fsm;

    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b100000;
    localparam logic [5:0] JMP  = 6'b111110;
    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] MUL  = 6'b011000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       alu_done;
    logic       ir_load, pc_load, mem_req, cu_mem_write, cu_reg_write, cu_op_sel, cu_ext_sel;
    logic [1:0] cu_pc_src, cu_reg_dst, cu_b_src, cu_wb_src;
    logic       alu_start, halted, fault;
    logic [17:0] all_outs;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .func         (func),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .alu_done     (alu_done),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .mem_req      (mem_req),
        .cu_mem_write (cu_mem_write),
        .cu_reg_write (cu_reg_write),
        .cu_op_sel    (cu_op_sel),
        .cu_ext_sel   (cu_ext_sel),
        .cu_pc_src    (cu_pc_src),
        .cu_reg_dst   (cu_reg_dst),
        .cu_b_src     (cu_b_src),
        .cu_wb_src    (cu_wb_src),
        .alu_start    (alu_start),
        .halted       (halted),
        .fault        (fault)
    );

    // halted is bit 1, fault is bit 0
    assign all_outs = {ir_load, pc_load, mem_req, cu_mem_write, cu_reg_write, cu_op_sel, cu_ext_sel,
                       cu_pc_src, cu_reg_dst, cu_b_src, cu_wb_src, alu_start, halted, fault};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, change inputs 1 time unit after the edge, then settle before checks.
    task automatic step(input logic rdy, input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        opcode    = op;
        func      = fn;
        zero      = z;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; func = '0; zero = 1'b0; alu_done = 1'b0;
        step(1, R_OP, ADD, 0);
        step(1, R_OP, ADD, 0);
        check("reset_outs", 32'(all_outs), 32'd0);

        // R-type with zero-wait memory: cycles 1..4 then back to FETCH
        rst_n = 1'b1;
        step(1, R_OP, ADD, 0);
        check("r_c1_mem_req", 32'(mem_req), 32'd1);
        check("r_c1_ir_load", 32'(ir_load), 32'd1);
        check("r_c1_pc_load", 32'(pc_load), 32'd1);
        check("r_c1_pc_src", 32'(cu_pc_src), 32'd0);
        step(1, R_OP, ADD, 0);
        check("r_c2_decode_quiet", 32'(all_outs), 32'd0);
        step(1, R_OP, ADD, 0);
        check("r_c3_op_sel", 32'(cu_op_sel), 32'd1);
        check("r_c3_no_regwrite", 32'(cu_reg_write), 32'd0);
        step(1, R_OP, ADD, 0);
        check("r_c4_reg_write", 32'(cu_reg_write), 32'd1);
        check("r_c4_reg_dst", 32'(cu_reg_dst), 32'd1);
        check("r_c4_wb_src", 32'(cu_wb_src), 32'd0);

        // LW: FETCH accept, DECODE, EXEC, 3 MEM waits, MEM accept, WB = 8 cycles
        step(1, LW, 6'd0, 0);
        check("lw_fetch_mem_req", 32'(mem_req), 32'd1);
        check("lw_fetch_no_regwrite", 32'(cu_reg_write), 32'd0);
        step(1, LW, 6'd0, 0);
        check("lw_decode_ignores_ready", 32'(ir_load), 32'd0);
        step(0, LW, 6'd0, 0);
        check("lw_exec_b_src", 32'(cu_b_src), 32'd1);
        check("lw_exec_ext_sel", 32'(cu_ext_sel), 32'd1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, LW, 6'd0, 0);
            n += int'(mem_req);
            check("lw_mem_no_write", 32'(cu_mem_write), 32'd0);
        end
        step(1, LW, 6'd0, 0);
        n += int'(mem_req);
        check("lw_mem_req_cycles", 32'(n), 32'd4);
        step(0, LW, 6'd0, 0);
        check("lw_wb_reg_write", 32'(cu_reg_write), 32'd1);
        check("lw_wb_wb_src", 32'(cu_wb_src), 32'd1);
        check("lw_wb_reg_dst", 32'(cu_reg_dst), 32'd0);

        // SW zero-wait: 4 cycles, write only in MEM
        step(1, SW, 6'd0, 0);
        check("sw_fetch_ir_load", 32'(ir_load), 32'd1);
        step(1, SW, 6'd0, 0);
        step(1, SW, 6'd0, 0);
        step(1, SW, 6'd0, 0);
        check("sw_mem_write", 32'(cu_mem_write), 32'd1);
        check("sw_mem_req", 32'(mem_req), 32'd1);

        // Branch zero=0 then zero=1
        step(1, BEQ, 6'd0, 0);
        check("sw_back_to_fetch", 32'(ir_load), 32'd1);
        check("sw_fetch_no_write", 32'(cu_mem_write), 32'd0);
        step(1, BEQ, 6'd0, 0);
        step(1, BEQ, 6'd0, 0);
        check("br_nz_pc_load", 32'(pc_load), 32'd1);
        check("br_nz_pc_src", 32'(cu_pc_src), 32'd3);
        step(1, BEQ, 6'd0, 1);
        check("br_fetch_ir_load", 32'(ir_load), 32'd1);
        step(1, BEQ, 6'd0, 1);
        step(1, BEQ, 6'd0, 1);
        check("br_z_pc_load", 32'(pc_load), 32'd1);
        check("br_z_pc_src", 32'(cu_pc_src), 32'd0);

        // Jump
        step(1, JMP, 6'd0, 0);
        check("j_fetch_ir_load", 32'(ir_load), 32'd1);
        step(1, JMP, 6'd0, 0);
        step(1, JMP, 6'd0, 0);
        check("j_pc_load", 32'(pc_load), 32'd1);
        check("j_pc_src", 32'(cu_pc_src), 32'd2);

        // FETCH: 14 waits, ready on the 15th cycle wins over the timeout
        for (int i = 0; i < 14; i++) step(0, R_OP, ADD, 0);
        check("wd_edge_still_fetch", 32'(mem_req), 32'd1);
        step(1, R_OP, ADD, 0);
        check("wd_edge_accept", 32'(ir_load), 32'd1);
        check("wd_edge_no_fault", 32'(fault), 32'd0);
        step(0, R_OP, ADD, 0);
        check("wd_edge_decode", 32'(all_outs), 32'd0);
        step(0, R_OP, ADD, 0);
        step(0, R_OP, ADD, 0);
        check("wd_edge_wb", 32'(cu_reg_write), 32'd1);

        // FETCH: 15 waits without ready -> FAULT
        for (int i = 0; i < 15; i++) step(0, R_OP, ADD, 0);
        check("wd_c15_no_fault_yet", 32'(fault), 32'd0);
        step(0, R_OP, ADD, 0);
        check("wd_fault", 32'(all_outs), 32'h1);
        step(1, R_OP, ADD, 0);
        step(1, R_OP, ADD, 0);
        check("wd_fault_sticky", 32'(all_outs), 32'h1);

        rst_n = 1'b0;
        step(1, R_OP, 6'd0, 0);
        check("fault_reset_clear", 32'(all_outs), 32'd0);
        rst_n = 1'b1;

        // HALT
        step(1, R_OP, 6'd0, 0);
        check("halt_fetch_mem_req", 32'(mem_req), 32'd1);
        step(1, R_OP, 6'd0, 0);
        step(1, R_OP, 6'd0, 0);
        check("halt_state", 32'(all_outs), 32'h2);
        step(1, R_OP, 6'd0, 1);
        check("halt_sticky", 32'(all_outs), 32'h2);
        rst_n = 1'b0;
        step(1, SW, 6'd0, 0);
        check("halt_reset_clear", 32'(all_outs), 32'd0);
        rst_n = 1'b1;

        // Store aborted by reset while waiting in MEM
        step(1, SW, 6'd0, 0);
        check("abort_fetch_mem_req", 32'(mem_req), 32'd1);
        step(1, SW, 6'd0, 0);
        step(0, SW, 6'd0, 0);
        step(0, SW, 6'd0, 0);
        check("abort_mem_write", 32'(cu_mem_write), 32'd1);
        rst_n = 1'b0;
        step(0, SW, 6'd0, 0);
        check("abort_no_write", 32'(all_outs), 32'd0);
        rst_n = 1'b1;

        // Unlisted opcode -> FAULT straight from DECODE
        step(1, 6'b000001, 6'd0, 0);
        step(1, 6'b000001, 6'd0, 0);
        step(1, 6'b000001, 6'd0, 0);
        check("illegal_fault", 32'(all_outs), 32'h1);
        rst_n = 1'b0;
        step(1, R_OP, MUL, 0);
        rst_n = 1'b1;

        // Multiply-class function
        step(1, R_OP, MUL, 0);
        check("mul_fetch_ir_load", 32'(ir_load), 32'd1);
        step(1, R_OP, MUL, 0);
        step(1, R_OP, MUL, 0);
`ifdef CU_LONGOP_EN
        check("mul_exec_op_sel", 32'(cu_op_sel), 32'd1);
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            step(0, R_OP, MUL, 0);
            alu_done = (i == 5);
            #1;
            n += int'(alu_start);
            if (i == 1) check("mul_start_first", 32'(alu_start), 32'd1);
        end
        check("mul_start_pulses", 32'(n), 32'd1);
        step(0, R_OP, MUL, 0);
        alu_done = 1'b0;
        #1;
        check("mul_wb_reg_write", 32'(cu_reg_write), 32'd1);
        check("mul_wb_src", 32'(cu_wb_src), 32'd2);
`else
        check("mul_illegal_fault", 32'(all_outs), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
